ccd_edge_post: RTL and testbench

Post-filter stage that sits directly downstream of the 3x3 convolution filter in the CCD edge pipeline. It consumes the filter's 24-bit signed `result` stream and its valid strobe, and converts each sample to an unsigned 10-bit edge magnitude or a binary edge map. It also blanks the one-pixel frame border, where the 3x3 window is invalid, and reports a per-frame edge-pixel count. Output feeds the display/frame-buffer path.

---
 rtl/ccd_edge_pkg.sv | 40 ++++
 rtl/mag_sat.sv | 54 +++++
 rtl/ccd_edge_post.sv | 176 +++++++++++++++++
 tb/tb_ccd_edge_post.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccd_edge_pkg
// Description : Shared widths, limits and pipeline tag types for the CCD
//               edge post-filter stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ccd_edge_pkg;

    localparam int PIX_W        = 10;
    localparam int RES_W        = 24;
    localparam int CNT_W        = 20;
    localparam int SHIFT_W      = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    localparam logic [PIX_W-1:0] PIX_MAX = 10'd1023;

    // Position attributes that travel alongside each sample.
    typedef struct packed {
        logic valid;
        logic start;
        logic last;
        logic border;
    } pos_tag_t;

    typedef struct packed {
        logic [PIX_W-1:0] threshold;
        logic             binary_mode;
    } dec_cfg_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mag_sat.sv
`default_nettype none
// ============================================================================
// Module      : mag_sat
// Description : Absolute value with saturation, then right-shift and clamp
//               to the pixel range. Two register stages.
// Revision    : 1.0 - initial release
// ============================================================================
module mag_sat
    import ccd_edge_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [RES_W-1:0]   i_result,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [PIX_W-1:0]   o_scaled
);

    logic [RES_W-1:0] w_mag;
    logic [RES_W-1:0] r_mag;
    logic [RES_W-1:0] w_shifted;
    logic [PIX_W-1:0] w_clamped;
    logic [PIX_W-1:0] r_scaled;

    always_comb begin
        w_mag = i_result;
        if (i_result[RES_W-1]) begin
            // The most negative code has no positive twin; pin it to max.
            if (i_result[RES_W-2:0] == '0)
                w_mag = {1'b0, {(RES_W-1){1'b1}}};
            else
                w_mag = -i_result;
        end
    end

    // i_shift is expected to be aligned with r_mag, i.e. one cycle after i_result.
    always_comb begin
        w_shifted = r_mag >> i_shift;
        w_clamped = (|w_shifted[RES_W-1:PIX_W]) ? PIX_MAX : w_shifted[PIX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag    <= '0;
            r_scaled <= '0;
        end else begin
            r_mag    <= w_mag;
            r_scaled <= w_clamped;
        end
    end

    assign o_scaled = r_scaled;

endmodule
`default_nettype wire

// File: rtl/ccd_edge_post.sv
`default_nettype none
// ============================================================================
// Module      : ccd_edge_post
// Description : Converts 3x3 filter results into 10-bit edge magnitude or a
//               binary edge map, blanks the frame border, counts edges/frame.
// Revision    : 1.0 - initial release
// ============================================================================
module ccd_edge_post
    import ccd_edge_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic               clk,
    input  logic               aclr,
    input  logic               data_valid_in,
    input  logic               frame_sync,
    input  logic [RES_W-1:0]   result,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [PIX_W-1:0]   threshold,
    input  logic               binary_mode,
    output logic [PIX_W-1:0]   pixel_out,
    output logic               edge_out,
    output logic               data_valid_out,
    output logic               frame_end,
    output logic [CNT_W-1:0]   edge_count,
    output logic               edge_count_valid
);

    localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int ROW_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(V_ACTIVE - 1);

    logic [COL_W-1:0]   r_col, w_col, w_col_nxt;
    logic [ROW_W-1:0]   r_row, w_row, w_row_nxt;
    logic               w_start, w_last, w_border;

    logic [SHIFT_W-1:0] r_sh_shift, w_shift_eff;
    dec_cfg_t           r_sh_cfg, w_cfg_eff;

    pos_tag_t           r_tag1, r_tag2;
    logic [SHIFT_W-1:0] r_shift1;
    dec_cfg_t           r_cfg1, r_cfg2;

    logic [PIX_W-1:0]   w_scaled;
    logic               w_edge;
    logic [PIX_W-1:0]   w_pix;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               w_frame_done;

    logic [PIX_W-1:0]   r_pixel_out;
    logic               r_edge_out;
    logic               r_data_valid_out;
    logic               r_frame_end;
    logic [CNT_W-1:0]   r_edge_count;

    // ---------------- position tracking ----------------
    always_comb begin
        w_col    = frame_sync ? '0 : r_col;
        w_row    = frame_sync ? '0 : r_row;
        w_start  = (w_col == '0) && (w_row == '0);
        w_last   = (w_col == c_COL_LAST) && (w_row == c_ROW_LAST);
        w_border = (w_col == '0) || (w_col == c_COL_LAST) ||
                   (w_row == '0) || (w_row == c_ROW_LAST);
        w_col_nxt = w_col + COL_W'(1);
        w_row_nxt = w_row;
        if (w_col == c_COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == c_ROW_LAST) ? '0 : w_row + ROW_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (data_valid_in) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // ---------------- config shadow ----------------
    // The frame's first sample already sees the new values, so bypass the shadow.
    always_comb begin
        w_shift_eff           = w_start ? shift : r_sh_shift;
        w_cfg_eff.threshold   = w_start ? threshold : r_sh_cfg.threshold;
        w_cfg_eff.binary_mode = w_start ? binary_mode : r_sh_cfg.binary_mode;
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_sh_shift <= '0;
            r_sh_cfg   <= '0;
        end else if (data_valid_in && w_start) begin
            r_sh_shift <= shift;
            r_sh_cfg   <= w_cfg_eff;
        end
    end

    // ---------------- stage 1/2 tag pipeline ----------------
    always_ff @(posedge clk) begin
        if (aclr) begin
            r_tag1   <= '0;
            r_tag2   <= '0;
            r_shift1 <= '0;
            r_cfg1   <= '0;
            r_cfg2   <= '0;
        end else begin
            r_tag1.valid  <= data_valid_in;
            r_tag1.start  <= w_start;
            r_tag1.last   <= w_last;
            r_tag1.border <= w_border;
            r_shift1      <= w_shift_eff;
            r_cfg1        <= w_cfg_eff;
            r_tag2        <= r_tag1;
            r_cfg2        <= r_cfg1;
        end
    end

    mag_sat u_mag_sat (
        .clk      (clk),
        .rst      (aclr),
        .i_result (result),
        .i_shift  (r_shift1),
        .o_scaled (w_scaled)
    );

    // ---------------- stage 3 decision and statistics ----------------
    always_comb begin
        w_edge = r_tag2.valid && !r_tag2.border && (w_scaled >= r_cfg2.threshold);
        if (r_tag2.border || !r_tag2.valid)
            w_pix = '0;
        else if (r_cfg2.binary_mode)
            w_pix = w_edge ? PIX_MAX : '0;
        else
            w_pix = w_scaled;
        // A (0,0) sample restarts the count, which also discards an aborted frame.
        w_cnt_nxt    = sat_inc(r_tag2.start ? '0 : r_cnt, w_edge);
        w_frame_done = r_tag2.valid && r_tag2.last;
    end

    always_ff @(posedge clk) begin
        if (aclr) begin
            r_pixel_out      <= '0;
            r_edge_out       <= 1'b0;
            r_data_valid_out <= 1'b0;
            r_frame_end      <= 1'b0;
            r_edge_count     <= '0;
            r_cnt            <= '0;
        end else begin
            r_pixel_out      <= w_pix;
            r_edge_out       <= w_edge;
            r_data_valid_out <= r_tag2.valid;
            r_frame_end      <= w_frame_done;
            if (r_tag2.valid) begin
                if (r_tag2.last) begin
                    r_edge_count <= w_cnt_nxt;
                    r_cnt        <= '0;
                end else begin
                    r_cnt        <= w_cnt_nxt;
                end
            end
        end
    end

    assign pixel_out        = r_pixel_out;
    assign edge_out         = r_edge_out;
    assign data_valid_out   = r_data_valid_out;
    assign frame_end        = r_frame_end;
    assign edge_count_valid = r_frame_end;
    assign edge_count       = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_ccd_edge_post.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccd_edge_post
// Description : Directed self-checking bench for ccd_edge_post (8x4 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccd_edge_post;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        aclr;
    logic        data_valid_in;
    logic        frame_sync;
    logic [23:0] result;
    logic [3:0]  shift;
    logic [9:0]  threshold;
    logic        binary_mode;
    logic [9:0]  pixel_out;
    logic        edge_out;
    logic        data_valid_out;
    logic        frame_end;
    logic [19:0] edge_count;
    logic        edge_count_valid;

    always #5 clk = ~clk;

    ccd_edge_post #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk              (clk),
        .aclr             (aclr),
        .data_valid_in    (data_valid_in),
        .frame_sync       (frame_sync),
        .result           (result),
        .shift            (shift),
        .threshold        (threshold),
        .binary_mode      (binary_mode),
        .pixel_out        (pixel_out),
        .edge_out         (edge_out),
        .data_valid_out   (data_valid_out),
        .frame_end        (frame_end),
        .edge_count       (edge_count),
        .edge_count_valid (edge_count_valid)
    );

    typedef struct packed {
        logic        v;
        logic        mk;
        logic [9:0]  pix;
        logic        edg;
        logic        fe;
        logic [19:0] ec;
    } exp_t;

    exp_t p0, p1, p2, cur;
    int n_checks = 0;
    int n_errors = 0;
    int n_fe     = 0;
    int m_col, m_row;
    logic [19:0] m_cnt, m_ec;
    logic [3:0]  m_sh;
    logic [9:0]  m_th;
    logic        m_bin;
    logic [9:0]  obs_pix;
    logic        obs_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        p2 = p1; p1 = p0; p0 = cur; cur = '0;
        chk("data_valid_out", 32'(data_valid_out), 32'(p2.v));
        chk("frame_end", 32'(frame_end), 32'(p2.fe));
        chk("edge_count_valid", 32'(edge_count_valid), 32'(p2.fe));
        if (frame_end === 1'b1) n_fe++;
        if (p2.v) begin
            chk("pixel_out", 32'(pixel_out), 32'(p2.pix));
            chk("edge_out", 32'(edge_out), 32'(p2.edg));
            chk("edge_count", 32'(edge_count), 32'(p2.ec));
            if (p2.mk) begin
                obs_pix  = pixel_out;
                obs_edge = edge_out;
            end
        end
    endtask

    function automatic logic [9:0] scale(input logic [23:0] res, input logic [3:0] sh);
        logic [23:0] mag;
        if (res == 24'h800000) mag = 24'h7FFFFF;
        else if (res[23])      mag = ~res + 24'd1;
        else                   mag = res;
        mag = mag >> sh;
        return (mag > 24'd1023) ? 10'd1023 : mag[9:0];
    endfunction

    task automatic send(input logic fs, input logic [23:0] res, input logic mk);
        logic       border, edg, last;
        logic [9:0] s, pix;
        data_valid_in = 1'b1;
        frame_sync    = fs;
        result        = res;
        if (fs) begin m_col = 0; m_row = 0; end
        if (m_col == 0 && m_row == 0) begin
            m_sh = shift; m_th = threshold; m_bin = binary_mode;
        end
        s      = scale(res, m_sh);
        border = (m_col == 0) || (m_col == H-1) || (m_row == 0) || (m_row == V-1);
        edg    = !border && (s >= m_th);
        pix    = border ? 10'd0 : (m_bin ? (edg ? 10'd1023 : 10'd0) : s);
        if (m_col == 0 && m_row == 0) m_cnt = 20'(edg);
        else if (m_cnt != 20'hFFFFF)  m_cnt = m_cnt + 20'(edg);
        last = (m_col == H-1) && (m_row == V-1);
        if (last) begin m_ec = m_cnt; m_cnt = '0; end
        cur = '{v:1'b1, mk:mk, pix:pix, edg:edg, fe:last, ec:m_ec};
        if (m_col == H-1) begin
            m_col = 0;
            m_row = (m_row == V-1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
        tick();
        data_valid_in = 1'b0;
        frame_sync    = 1'b0;
    endtask

    task automatic run(input int n, input bit fs0, input logic [23:0] fill, input int sp,
                       input logic [23:0] sp_res, input bit bub, input int chg,
                       input logic [9:0] chg_thr);
        obs_pix  = 10'h3AA;
        obs_edge = 1'bx;
        for (int i = 0; i < n; i++) begin
            if (i == chg) threshold = chg_thr;
            send(fs0 && (i == 0), (i == sp) ? sp_res : fill, i == sp);
            if (bub) tick();
        end
    endtask

    task automatic flush();
        repeat (3) tick();
    endtask

    task automatic do_reset(input int n);
        aclr = 1'b1;
        data_valid_in = 1'b1;
        frame_sync = 1'b0;
        result = 24'd1000;
        p0 = '0; p1 = '0; p2 = '0; cur = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rst_pixel_out", 32'(pixel_out), 32'd0);
            chk("rst_edge_out", 32'(edge_out), 32'd0);
            chk("rst_edge_count", 32'(edge_count), 32'd0);
        end
        aclr = 1'b0;
        data_valid_in = 1'b0;
        m_col = 0; m_row = 0; m_cnt = '0; m_ec = '0;
        m_sh = '0; m_th = '0; m_bin = 1'b0;
    endtask

    initial begin
        aclr = 1'b1; data_valid_in = 1'b0; frame_sync = 1'b0; result = '0;
        shift = '0; threshold = '0; binary_mode = 1'b0;
        do_reset(2);

        // interior magnitude: (2,1) = -256 >> 2 = 64
        shift = 4'd2; threshold = 10'd50; binary_mode = 1'b0;
        run(32, 1, 24'd0, 10, 24'hFFFF00, 0, -1, 10'd0);
        flush();
        chk("mag_pix_thr50", 32'(obs_pix), 32'd64);
        chk("mag_edge_thr50", 32'(obs_edge), 32'd1);
        chk("mag_count_thr50", 32'(edge_count), 32'd1);
        threshold = 10'd65;
        run(32, 1, 24'd0, 10, 24'hFFFF00, 0, -1, 10'd0);
        flush();
        chk("mag_pix_thr65", 32'(obs_pix), 32'd64);
        chk("mag_edge_thr65", 32'(obs_edge), 32'd0);
        chk("mag_count_thr65", 32'(edge_count), 32'd0);

        // saturation of -2^23 at (1,1)
        threshold = 10'd1023;
        shift = 4'd0;
        run(32, 1, 24'd0, 9, 24'h800000, 0, -1, 10'd0);
        flush();
        chk("sat_shift0", 32'(obs_pix), 32'd1023);
        shift = 4'd13;
        run(32, 1, 24'd0, 9, 24'h800000, 0, -1, 10'd0);
        flush();
        chk("sat_shift13", 32'(obs_pix), 32'd1023);
        shift = 4'd14;
        run(32, 1, 24'd0, 9, 24'h800000, 0, -1, 10'd0);
        flush();
        chk("sat_shift14", 32'(obs_pix), 32'd511);

        // border blanking and edge count
        shift = 4'd0; threshold = 10'd1; binary_mode = 1'b1;
        n_fe = 0;
        run(32, 1, 24'd1000, 9, 24'd1000, 0, -1, 10'd0);
        flush();
        chk("border_count", 32'(edge_count), 32'd12);
        chk("border_interior_pix", 32'(obs_pix), 32'd1023);
        chk("border_frame_ends", 32'(n_fe), 32'd1);

        // bubbles on every other cycle
        n_fe = 0;
        run(32, 1, 24'd1000, 0, 24'd1000, 1, -1, 10'd0);
        flush();
        chk("bubble_count", 32'(edge_count), 32'd12);
        chk("bubble_border_pix", 32'(obs_pix), 32'd0);
        chk("bubble_frame_ends", 32'(n_fe), 32'd1);

        // threshold raised mid-frame only applies from the next frame
        binary_mode = 1'b0; threshold = 10'd1;
        run(32, 1, 24'd1000, 17, 24'd1000, 0, 16, 10'd1001);
        flush();
        chk("shadow_pix", 32'(obs_pix), 32'd1000);
        chk("shadow_edge", 32'(obs_edge), 32'd1);
        chk("shadow_count", 32'(edge_count), 32'd12);
        run(32, 1, 24'd1000, 17, 24'd1000, 0, -1, 10'd0);
        flush();
        chk("shadow_next_edge", 32'(obs_edge), 32'd0);
        chk("shadow_next_count", 32'(edge_count), 32'd0);

        // resync on input 13 of a frame
        threshold = 10'd1;
        n_fe = 0;
        run(12, 1, 24'd1000, -1, 24'd0, 0, -1, 10'd0);
        run(32, 1, 24'd1000, 0, 24'd1000, 0, -1, 10'd0);
        flush();
        chk("resync_pix", 32'(obs_pix), 32'd0);
        chk("resync_edge", 32'(obs_edge), 32'd0);
        chk("resync_count", 32'(edge_count), 32'd12);
        chk("resync_frame_ends", 32'(n_fe), 32'd1);

        // reset mid-frame; next frame starts without frame_sync
        run(10, 1, 24'd1000, -1, 24'd0, 0, -1, 10'd0);
        do_reset(3);
        n_fe = 0;
        run(32, 0, 24'd1000, 9, 24'd1000, 0, -1, 10'd0);
        flush();
        chk("post_rst_pix", 32'(obs_pix), 32'd1000);
        chk("post_rst_count", 32'(edge_count), 32'd12);
        chk("post_rst_frame_ends", 32'(n_fe), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
